// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: first-word-fall-through FIFO of {pc, inst} pairs.
// Optional zero-latency empty-queue bypass enabled with `define IQ_BYPASS_EN.
module inst_queue #(
   parameter int DEPTH        = 4,
   parameter int AFULL_THRESH = 3,
   localparam int CNT_W       = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             flush,
   input  logic             push_valid,
   input  logic [31:0]      push_pc,
   input  logic [31:0]      push_inst,
   output logic             push_ready,
   output logic             pop_valid,
   output logic [31:0]      pop_pc,
   output logic [31:0]      pop_inst,
   input  logic             pop_ready,
   output logic [CNT_W-1:0] count,
   output logic             almost_full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [63:0]      entry_q [DEPTH];
   logic [63:0]      head_entry;
   logic             not_empty;
   logic             not_full;
   logic             bypass_fire;
   logic             push_fire;
   logic             pop_fire;

   assign not_empty  = (count_q != '0);
   assign not_full   = (count_q != CNT_W'(DEPTH));
   assign head_entry = entry_q[rd_ptr_q];

`ifdef IQ_BYPASS_EN
   // An empty queue hands the fetched word straight to a ready decoder without storing it.
   assign bypass_fire = ~not_empty & push_valid & pop_ready & ~flush;
`else
   assign bypass_fire = 1'b0;
`endif

   // Full refuses a push even when a pop happens in the same cycle; fetch must hold.
   assign push_ready = ~flush & not_full;
   assign pop_valid  = (not_empty | bypass_fire) & ~flush;
   assign push_fire  = push_valid & push_ready & ~bypass_fire;
   assign pop_fire   = not_empty & ~flush & pop_ready;

   assign count       = count_q;
   assign empty       = ~not_empty;
   assign almost_full = (count_q >= CNT_W'(AFULL_THRESH));

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      pop_pc   = 32'd0;
      pop_inst = 32'd0;
      if (bypass_fire) begin
         pop_pc   = push_pc;
         pop_inst = push_inst;
      end else if (not_empty) begin
         pop_pc   = head_entry[63:32];
         pop_inst = head_entry[31:0];
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         unique case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state is assigned with non-blocking <= so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the entry array has no reset; count gates every read, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push_fire) entry_q[wr_ptr_q] <= {push_pc, push_inst};
   end

endmodule
